// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU share arbiter.
// - ALU opcode encodings (values driven straight onto the ALU result-mux select).
// - FSM state encoding used by the arbiter top.
package alu_share_arbiter_pkg;

    // ALU result-mux select encodings
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational 2-way round-robin grant.
// Ports:
//   valid0_i, valid1_i : request lines
//   last_grant_i       : requester granted most recently (0/1)
//   grant0_o, grant1_o : one-hot (or zero) grant
module rr_arbiter_2 (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic grant0_o,
    output logic grant1_o
);

    // On a tie the requester that did not win last time takes the grant.
    always_comb begin
        grant0_o = valid0_i & (~valid1_i | last_grant_i);
        grant1_o = valid1_i & (~valid0_i | ~last_grant_i);
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// A granted request is registered onto alu_a/alu_b/alu_sel, the ALU result is
// captured one cycle later and returned on the response port tagged by rsp_id.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b     : requester N operation port (N = 0, 1)
//   alu_a, alu_b, alu_sel       : registered ALU inputs
//   alu_result                  : combinational ALU output
//   rsp_valid/ready/id/data     : response port
//   busy                        : FSM is not idle
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_sel_q, alu_sel_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic grant0, grant1;
    logic accept_en;

    rr_arbiter_2 u_rr (
        .valid0_i     (req0_valid),
        .valid1_i     (req1_valid),
        .last_grant_i (last_grant_q),
        .grant0_o     (grant0),
        .grant1_o     (grant1)
    );

    // Ready is suppressed while reset is asserted so nothing looks accepted.
    assign accept_en  = (state_q == StIdle) && !reset;
    assign req0_ready = accept_en && grant0;
    assign req1_ready = accept_en && grant1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        unique case (state_q)
            StIdle: begin
                if (req0_valid && req0_ready) begin
                    alu_a_d      = req0_a;
                    alu_b_d      = req0_b;
                    alu_sel_d    = req0_op;
                    rsp_id_d     = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = StExec;
                end else if (req1_valid && req1_ready) begin
                    alu_a_d      = req1_a;
                    alu_b_d      = req1_b;
                    alu_sel_d    = req1_op;
                    rsp_id_d     = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = StExec;
                end
            end
            StExec: begin
                rsp_data_d  = alu_result;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_sel;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_data;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] sweep_exp [8];

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .OPW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    // Reference ALU driven by the DUT's registered ALU inputs.
    always_comb begin
        alu_result = 32'h0;
        case (alu_sel)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_XOR: alu_result = alu_a ^ alu_b;
            ALU_SLL: alu_result = alu_a << alu_b[4:0];
            ALU_SRL: alu_result = alu_a >> alu_b[4:0];
            ALU_SLT: alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = 32'h0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    initial begin
        sweep_exp[0] = 32'h0F0E0F0F;
        sweep_exp[1] = 32'hF0EFF0F1;
        sweep_exp[2] = 32'h0F0F0000;
        sweep_exp[3] = 32'hFFFF0F0F;
        sweep_exp[4] = 32'hF0F00F0F;
        sweep_exp[5] = 32'h80000000;
        sweep_exp[6] = 32'h0001FFFE;
        sweep_exp[7] = 32'h00000001;

        reset = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'd5; req0_b = 32'd7;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = 32'd0; req1_b = 32'd0;
        rsp_ready = 1'b0;
        tick();
        tick();

        // Reset state, with a request pending that must not be readied.
        chk("rst_req0_ready", {31'h0, req0_ready}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_sel", {29'h0, alu_sel}, 32'd0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);

        // Single request: op 2 (AND) 5 & 7 = 5.
        reset = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("single_req0_ready", {31'h0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("single_alu_sel", {29'h0, alu_sel}, 32'd2);
        chk("single_alu_a", alu_a, 32'd5);
        chk("single_alu_b", alu_b, 32'd7);
        chk("single_exec_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("single_busy", {31'h0, busy}, 32'd1);
        tick();
        chk("single_rsp_valid", {31'h0, rsp_valid}, 32'd1);
        chk("single_rsp_id", {31'h0, rsp_id}, 32'd0);
        chk("single_rsp_data", rsp_data, 32'd5);
        tick();
        chk("single_done_valid", {31'h0, rsp_valid}, 32'd0);
        chk("single_done_busy", {31'h0, busy}, 32'd0);

        // Tie after reset: req0 first, then strict alternation.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd1;  req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 32'd10; req1_b = 32'd3;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("tie_req0_ready", {31'h0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("tie_req1_ready", {31'h0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("tie_exec_ready", {30'h0, req1_ready, req0_ready}, 32'd0);
            tick();
            chk("tie_rsp_id", {31'h0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("tie_rsp_data", rsp_data, (i % 2 == 0) ? 32'd2 : 32'd7);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure, with req1 changing its operand while blocked.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd4; req0_a = 32'hF0; req0_b = 32'hFF;
        #1;
        chk("bp_req0_ready", {31'h0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'd1; req1_b = 32'd2;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", rsp_data, 32'h0F);
            chk("bp_rsp_id", {31'h0, rsp_id}, 32'd0);
            chk("bp_ready", {30'h0, req1_ready, req0_ready}, 32'd0);
            chk("bp_busy", {31'h0, busy}, 32'd1);
            if (i == 2) req1_a = 32'd9;
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", {31'h0, rsp_valid}, 32'd0);
        chk("bp_release_busy", {31'h0, busy}, 32'd0);
        chk("opchg_req1_ready", {31'h0, req1_ready}, 32'd1);
        rsp_ready = 1'b0;
        tick();
        req1_valid = 1'b0;
        chk("opchg_alu_a", alu_a, 32'd9);
        tick();
        chk("opchg_rsp_valid", {31'h0, rsp_valid}, 32'd1);
        chk("opchg_rsp_id", {31'h0, rsp_id}, 32'd1);
        chk("opchg_rsp_data", rsp_data, 32'd11);

        // Reset while a response is pending: dropped, outputs back to reset values.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rresp_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rresp_alu_a", alu_a, 32'd0);
        chk("rresp_alu_b", alu_b, 32'd0);
        chk("rresp_alu_sel", {29'h0, alu_sel}, 32'd0);
        chk("rresp_busy", {31'h0, busy}, 32'd0);
        chk("rresp_rsp_data", rsp_data, 32'd0);
        req0_valid = 1'b1; req0_op = 3'd3; req0_a = 32'h30; req0_b = 32'h0C;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("rresp_req0_ready", {31'h0, req0_ready}, 32'd1);
        chk("rresp_req1_ready", {31'h0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("rresp_after_valid", {31'h0, rsp_valid}, 32'd1);
        chk("rresp_after_id", {31'h0, rsp_id}, 32'd0);
        chk("rresp_after_data", rsp_data, 32'h3C);
        tick();

        // Opcode sweep.
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1;
            req0_op = 3'(i);
            req0_a = 32'hFFFF0000;
            req0_b = 32'h0F0F0F0F;
            tick();
            req0_valid = 1'b0;
            chk("sweep_alu_sel", {29'h0, alu_sel}, 32'(i));
            tick();
            chk("sweep_rsp_data", rsp_data, sweep_exp[i]);
            tick();
            chk("sweep_done", {31'h0, rsp_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters. The ALU's result stage is the 8:1 32-bit mux with a 3-bit select.
- Accepts operation requests on two valid/ready ports and arbitrates round-robin.
- Registers the winning opcode and operands onto the ALU inputs, captures the ALU result one cycle later and returns it on a single response port tagged with the requester ID.
- Sits between the register-file/issue logic and the ALU top.

Parameters:
- WIDTH, 32, operand/result width (must equal ALU width).
- OPW, 3, opcode width; drives the ALU result-mux select directly.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 request accepted this cycle when high together with req0_valid.
- req0_op  input  OPW  requester 0 opcode (ALU select value 0..7).
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- alu_a  output  WIDTH  registered operand A to ALU.
- alu_b  output  WIDTH  registered operand B to ALU.
- alu_sel  output  OPW  registered ALU result-mux select.
- alu_result  input  WIDTH  ALU output (combinational from alu_a/alu_b/alu_sel).
- rsp_valid  output  1  response holds a result.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  requester that issued the result (0/1).
- rsp_data  output  WIDTH  captured ALU result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high; it is sampled only on the rising edge of `clk`.
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - alu_a=0, alu_b=0, alu_sel=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req0_ready=0 and req1_ready=0 while reset is high.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational: only one valid → that requester; both valid → the requester that is NOT last_grant.
  - reqN_ready=1 only for the granted requester, and only in IDLE; both ready=0 in EXEC and RESP.
  - On reqN_valid&&reqN_ready:
    - alu_a/alu_b/alu_sel <= reqN_a/b/op.
    - rsp_id <= N, last_grant <= N.
    - Go to EXEC.
  - No valid → stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_* stable; rsp_data <= alu_result; rsp_valid <= 1.
  - Go to RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready: rsp_valid <= 0, go to IDLE.
  - No new request is accepted in the same cycle.
- Latency and throughput:
  - Accept edge N → rsp_valid high after edge N+1 → visible in cycle N+2.
  - Minimum 3 cycles per operation.
- alu_a/alu_b/alu_sel keep their last values after completion; they are not cleared.
- Opcode values 0..7 all pass through unchecked; no illegal opcode exists.
- Requester-side rules:
  - A requester holding valid may change op/operands before acceptance; only the values present at the accept edge are used.
  - Valid deasserting before acceptance is permitted (no lock).
- Simultaneous valid with alternating history: strict alternation. Requests r0,r1,r0,r1… with both always valid yields grants 0,1,0,1.
- Reset mid-operation (EXEC or RESP): the in-flight operation is dropped with no response, and all outputs return to reset values on the next edge.
- rsp_ready high while rsp_valid=0: ignored.

Decomposition:
- Shared include file `aluComponents/alu_defs.v` holds:
  - ALU opcode constants (select encodings 0..7).
  - FSM state encodings: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- One natural sub-module, `rr_arbiter_2`: combinational 2-way round-robin grant from {valid0, valid1, last_grant}.
- The FSM and registers stay in the top module.

Test Plan:
- Single request: after reset, req0 op=3'd2 a=5 b=7, rsp_ready=1. Required: req0_ready=1 in that cycle; alu_sel=2, alu_a=5, alu_b=7 next cycle; rsp_valid=1, rsp_id=0, rsp_data=ALU model result two cycles after accept; back to IDLE.
- Tie at reset: req0 and req1 both valid in the same cycle. Required: req0 granted first, then req1. With both held valid for 4 ops, grant order is 0,1,0,1 and rsp_id follows it.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises. Required: rsp_data/rsp_id stable, both ready=0, busy=1 throughout; after rsp_ready=1 for one cycle, rsp_valid=0 and IDLE is re-entered.
- Operand change before accept: req1 valid while the block is busy, with operands changed from a=1 to a=9 before grant. Required: ALU sees a=9.
- Reset in RESP: assert reset one cycle while rsp_valid=1. Required: next cycle rsp_valid=0, alu_*=0, busy=0, no response emitted; the following request is served normally with req0 priority.
- All opcodes: sweep op=0..7 with a=32'hFFFF0000, b=32'h0F0F0F0F. Required: each rsp_data matches the ALU reference model, and alu_sel equals op.
